peribus_gpio_bank: RTL

//  Parametrised peripheral-bus GPIO bank: NUM_PORTS ports, each with data, direction,
//  irq-enable and irq-status registers. Any-edge input interrupts drive one irq line.

---
 rtl/peribus_gpio_bank.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/peribus_gpio_bank.sv
// Peribus GPIO bank: NUM_PORTS ports of DATA/DIR/IEN/ISR registers with any-edge interrupts.
// Optional input debounce is compiled in when GPIO_DEBOUNCE_EN is defined.
module peribus_gpio_bank #(
    parameter int NUM_PORTS       = 2,
    parameter int PORT_WIDTH      = 16,
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                            CLOCK_50,
    input  logic                            reset_n,
    input  logic [ADDR_WIDTH-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]           write_data,
    output logic [DATA_WIDTH-1:0]           read_data,
    input  logic                            write_enable,
    input  logic                            read_enable,
    output logic                            irq,
    inout  wire  [NUM_PORTS*PORT_WIDTH-1:0] pins
);

    localparam int PINS   = NUM_PORTS * PORT_WIDTH;
    localparam int PIDX_W = ADDR_WIDTH - 2;

    logic [ADDR_WIDTH-1:0] off;
    logic [PIDX_W-1:0]     port_idx;
    logic [1:0]            reg_sel;
    logic                  mapped;
    logic [PORT_WIDTH-1:0] wd;

    logic [PORT_WIDTH-1:0] latch_q [NUM_PORTS];
    logic [PORT_WIDTH-1:0] dir_q   [NUM_PORTS];
    logic [PORT_WIDTH-1:0] ien_q   [NUM_PORTS];
    logic [PORT_WIDTH-1:0] isr_q   [NUM_PORTS];

    logic [PINS-1:0]       sync1_q, sync2_q, prev_q, filt, edge_v;
    logic [1:0]            settle_q;
    logic                  settle_done;
    logic [NUM_PORTS-1:0]  wr_port;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  any_irq;

    assign off      = addr - BASE_ADDR;
    assign port_idx = off[ADDR_WIDTH-1:2];
    assign reg_sel  = off[1:0];
    assign mapped   = (addr >= BASE_ADDR) &&
                      ({{(32-PIDX_W){1'b0}}, port_idx} < 32'(NUM_PORTS));
    assign wd       = write_data[PORT_WIDTH-1:0];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        for (genvar b = 0; b < PORT_WIDTH; b++) begin : g_bit
            assign pins[p*PORT_WIDTH+b] = dir_q[p][b] ? latch_q[p][b] : 1'bz;
        end
    end

    // Edges are masked until the synchroniser has flushed the reset-time zeros.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            settle_q <= '0;
        end else begin
            sync1_q <= pins;
            sync2_q <= sync1_q;
            prev_q  <= filt;
            if (!settle_done)
                settle_q <= settle_q + 2'd1;
        end
    end

    assign settle_done = (settle_q == 2'd3);

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [PINS-1:0]  deb_q, last_q;
    logic [CNT_W-1:0] cnt_q [NUM_PORTS];

    // A port's filtered value follows only once its synced vector has held still.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            deb_q  <= '0;
            last_q <= '0;
            for (int p = 0; p < NUM_PORTS; p++)
                cnt_q[p] <= '0;
        end else begin
            last_q <= sync2_q;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sync2_q[p*PORT_WIDTH +: PORT_WIDTH] != last_q[p*PORT_WIDTH +: PORT_WIDTH])
                    cnt_q[p] <= '0;
                else if (cnt_q[p] != CNT_W'(DEBOUNCE_CYCLES))
                    cnt_q[p] <= cnt_q[p] + 1'b1;
                if (cnt_q[p] == CNT_W'(DEBOUNCE_CYCLES))
                    deb_q[p*PORT_WIDTH +: PORT_WIDTH] <= last_q[p*PORT_WIDTH +: PORT_WIDTH];
            end
        end
    end

    assign filt = deb_q;
`else
    assign filt = sync2_q;
`endif

    assign edge_v = (filt ^ prev_q) & {PINS{settle_done}};

    always_comb begin
        wr_port = '0;
        rd_mux  = '0;
        any_irq = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            any_irq = any_irq | (|(isr_q[p] & ien_q[p]));
            if (mapped && port_idx == PIDX_W'(p)) begin
                wr_port[p] = write_enable;
                case (reg_sel)
                    2'd0:    rd_mux = DATA_WIDTH'(filt[p*PORT_WIDTH +: PORT_WIDTH]);
                    2'd1:    rd_mux = DATA_WIDTH'(dir_q[p]);
                    2'd2:    rd_mux = DATA_WIDTH'(ien_q[p]);
                    default: rd_mux = DATA_WIDTH'(isr_q[p]);
                endcase
            end
        end
    end

    // ISR clears by W1C but a same-cycle edge re-sets the bit.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                latch_q[p] <= '0;
                dir_q[p]   <= '0;
                ien_q[p]   <= '0;
                isr_q[p]   <= '0;
            end
            read_data <= '0;
            irq       <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_port[p]) begin
                    case (reg_sel)
                        2'd0:    latch_q[p] <= wd;
                        2'd1:    dir_q[p]   <= wd;
                        2'd2:    ien_q[p]   <= wd;
                        default: ;
                    endcase
                end
                isr_q[p] <= (isr_q[p] & ~((wr_port[p] && reg_sel == 2'd3) ? wd : '0))
                            | edge_v[p*PORT_WIDTH +: PORT_WIDTH];
            end
            if (read_enable)
                read_data <= rd_mux;
            irq <= any_irq;
        end
    end

endmodule
